// File: rtl/sevenseg_rx.sv
// -----------------------------------------------------------------------------
// sevenseg_rx
//
// Receive-side decoder for a multiplexed 4-digit 7-segment display bus.
//
// The block watches the active-low common lines and segment lines, waits for
// each value to settle, and decodes the segment pattern back to a BCD digit.
// Once all four positions have been captured, the frame is published with a
// one-cycle frame_valid strobe.
//
// Optional feature macro: SEVENSEG_RX_SYNC_EN
//   defined   : com/seg_data pass through a 2-flop synchronizer (pin inputs).
//   undefined : inputs feed the stability filter directly (same-clock loopback).
//
// Parameters
//   P_STABLE_CNT : cycles a {com, seg_data} value must hold before sampling
//   P_TIMEOUT    : cycles without any sample event before the frame goes stale
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   com[3:0]     : common lines, active-low one-hot (bit n selects digit n)
//   seg_data[7:0]: {dp, g, f, e, d, c, b, a}, active-low
//   digit0..3    : decoded digits of the last complete frame
//   dp_pos[3:0]  : bit n set when digit n had its decimal point lit
//   frame_valid  : one-cycle pulse when digit/dp outputs update
//   seg_err      : one-cycle pulse on a sample with illegal com or segment code
//   stale        : set on timeout, cleared by the next frame_valid
// -----------------------------------------------------------------------------
module sevenseg_rx #(
  parameter int P_STABLE_CNT = 15,
  parameter int P_TIMEOUT    = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] com,
  input  logic [7:0] seg_data,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] dp_pos,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       stale
);

  localparam logic [7:0]  STABLE_MAX  = 8'(P_STABLE_CNT);
  localparam logic [19:0] TIMEOUT_MAX = 20'(P_TIMEOUT);

  typedef enum logic {
    S_COLLECT,
    S_PUBLISH
  } state_t;

  // Observed bus value {com, seg_data}
  logic [11:0] obs;

`ifdef SEVENSEG_RX_SYNC_EN
  logic [11:0] sync1_q, sync1_d;
  logic [11:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = {com, seg_data};
    sync2_d = sync1_q;
  end

  // Reset to the "everything off" bus value so no spurious change is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 12'hFFF;
      sync2_q <= 12'hFFF;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign obs = sync2_q;
`else
  assign obs = {com, seg_data};
`endif

  logic [3:0] com_obs;
  logic [7:0] seg_obs;
  assign com_obs = obs[11:8];
  assign seg_obs = obs[7:0];

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [11:0] prev_q,        prev_d;
  logic [7:0]  stab_q,        stab_d;
  logic [19:0] tmo_q,         tmo_d;
  logic [3:0]  mask_q,        mask_d;
  logic [15:0] shadow_dig_q,  shadow_dig_d;
  logic [3:0]  shadow_dp_q,   shadow_dp_d;
  logic [15:0] out_dig_q,     out_dig_d;
  logic [3:0]  dp_pos_q,      dp_pos_d;
  logic        frame_valid_q, frame_valid_d;
  logic        seg_err_q,     seg_err_d;
  logic        stale_q,       stale_d;
  state_t      state_q,       state_d;

  // ---------------------------------------------------------------------------
  // Stability filter: one sample event per stable period, on the edge where
  // the counter steps from STABLE_MAX-1 to STABLE_MAX.
  // ---------------------------------------------------------------------------
  logic sample;

  always_comb begin
    prev_d = obs;
    stab_d = stab_q;
    sample = 1'b0;
    if (obs != prev_q) begin
      stab_d = 8'd0;
    end else begin
      if (stab_q != STABLE_MAX) begin
        stab_d = stab_q + 8'd1;
      end
      sample = (stab_q == STABLE_MAX - 8'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // com / segment decode
  // ---------------------------------------------------------------------------
  logic       com_valid;
  logic       com_idle;
  logic [3:0] seg_digit;
  logic       seg_bad;

  always_comb begin
    com_valid = 1'b0;
    case (com_obs)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: com_valid = 1'b1;
      default:                            com_valid = 1'b0;
    endcase
  end

  assign com_idle = &com_obs;

  always_comb begin
    seg_bad   = 1'b0;
    seg_digit = 4'hE;
    case (seg_obs[6:0])
      7'h40:   seg_digit = 4'd0;
      7'h79:   seg_digit = 4'd1;
      7'h24:   seg_digit = 4'd2;
      7'h30:   seg_digit = 4'd3;
      7'h19:   seg_digit = 4'd4;
      7'h12:   seg_digit = 4'd5;
      7'h02:   seg_digit = 4'd6;
      7'h78:   seg_digit = 4'd7;
      7'h00:   seg_digit = 4'd8;
      7'h10:   seg_digit = 4'd9;
      7'h7F:   seg_digit = 4'hF;  // blank digit, not an error
      default: begin
        seg_digit = 4'hE;
        seg_bad   = 1'b1;
      end
    endcase
  end

  logic capture;
  logic [3:0] sel;

  assign capture   = sample & com_valid;
  // An illegal segment pattern is still captured (as 4'hE) but flagged.
  assign seg_err_d = sample & ~com_idle & (~com_valid | seg_bad);

  // ---------------------------------------------------------------------------
  // Per-position shadow registers
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pos
      // com is active-low one-hot, so the low bit marks the position.
      assign sel[gi] = capture & ~com_obs[gi];
      assign shadow_dig_d[gi*4 +: 4] = sel[gi] ? seg_digit : shadow_dig_q[gi*4 +: 4];
      assign shadow_dp_d[gi]         = sel[gi] ? ~seg_obs[7] : shadow_dp_q[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Timeout: cleared by any sample event, holds at TIMEOUT_MAX.
  // ---------------------------------------------------------------------------
  logic tmo_hit;

  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (sample) begin
      tmo_d = 20'd0;
    end else if (tmo_q != TIMEOUT_MAX) begin
      tmo_d   = tmo_q + 20'd1;
      tmo_hit = (tmo_q == TIMEOUT_MAX - 20'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    out_dig_d     = out_dig_q;
    dp_pos_d      = dp_pos_q;
    frame_valid_d = 1'b0;

    case (state_q)
      S_COLLECT: begin
        mask_d = mask_q | sel;
        if (tmo_hit) begin
          mask_d = 4'b0000;
        end
        if (mask_d == 4'b1111) begin
          state_d = S_PUBLISH;
        end
      end
      S_PUBLISH: begin
        out_dig_d     = shadow_dig_q;
        dp_pos_d      = shadow_dp_q;
        frame_valid_d = 1'b1;
        // A capture landing here starts the next frame's mask.
        mask_d        = sel;
        state_d       = S_COLLECT;
      end
      default: begin
        state_d = S_COLLECT;
        mask_d  = 4'b0000;
      end
    endcase

    stale_d = stale_q;
    if (frame_valid_d) begin
      stale_d = 1'b0;
    end else if (tmo_hit) begin
      stale_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q        <= 12'hFFF;
      stab_q        <= 8'd0;
      tmo_q         <= 20'd0;
      mask_q        <= 4'b0000;
      shadow_dig_q  <= 16'hFFFF;
      shadow_dp_q   <= 4'b0000;
      out_dig_q     <= 16'hFFFF;
      dp_pos_q      <= 4'b0000;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      stale_q       <= 1'b0;
      state_q       <= S_COLLECT;
    end else begin
      prev_q        <= prev_d;
      stab_q        <= stab_d;
      tmo_q         <= tmo_d;
      mask_q        <= mask_d;
      shadow_dig_q  <= shadow_dig_d;
      shadow_dp_q   <= shadow_dp_d;
      out_dig_q     <= out_dig_d;
      dp_pos_q      <= dp_pos_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      stale_q       <= stale_d;
      state_q       <= state_d;
    end
  end

  assign digit0      = out_dig_q[3:0];
  assign digit1      = out_dig_q[7:4];
  assign digit2      = out_dig_q[11:8];
  assign digit3      = out_dig_q[15:12];
  assign dp_pos      = dp_pos_q;
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_sevenseg_rx.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_rx
//
// Drives the display bus as a list of constant "runs" (value held for N
// cycles). A reference model works at the run level: any run lasting at least
// P_STABLE_CNT+1 cycles yields one sample event, which the model decodes from
// the segment table and folds into a 4-position frame. Completed frames are
// queued; a monitor pops them whenever frame_valid pulses.
// -----------------------------------------------------------------------------
module tb_sevenseg_rx;

  localparam int P   = 15;
  localparam int TMO = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] com;
  logic [7:0] seg_data;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] dp_pos;
  logic       frame_valid, seg_err, stale;

  always #5 clk = ~clk;

  sevenseg_rx #(
    .P_STABLE_CNT(P),
    .P_TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .com        (com),
    .seg_data   (seg_data),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .dp_pos     (dp_pos),
    .frame_valid(frame_valid),
    .seg_err    (seg_err),
    .stale      (stale)
  );

  // Segment patterns (bits 6:0, active-low) for digits 0..9
  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [3:0] BAD_COM [11] = '{4'b0000, 4'b0011, 4'b0101, 4'b0110,
                                          4'b1001, 4'b1010, 4'b1100, 4'b0001,
                                          4'b0010, 4'b0100, 4'b1000};

  typedef struct packed {
    logic [15:0] digs;
    logic [3:0]  dp;
  } frame_t;

  frame_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int err_exp = 0;
  int err_seen = 0;

  // Reference model state
  logic [3:0]  m_dig [4];
  logic [3:0]  m_dp;
  logic [3:0]  m_mask;
  logic [15:0] m_last_digs;
  logic [3:0]  m_last_dp;
  logic [11:0] last_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    if (p == 7'h7F) return 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (SEG_TAB[k] == p) return 4'(k);
    end
    return 4'hE;
  endfunction

  function automatic logic [3:0] com_of(input int pos);
    return ~(4'b0001 << pos);
  endfunction

  function automatic logic [7:0] seg_of(input int d, input logic dp_lit);
    return {~dp_lit, SEG_TAB[d]};
  endfunction

  task automatic model_event(input logic [3:0] c, input logic [7:0] s);
    int pos;
    frame_t f;
    pos = -1;
    if (c == 4'hF) return;
    for (int n = 0; n < 4; n++) begin
      if (c == com_of(n)) pos = n;
    end
    if (pos < 0) begin
      err_exp++;
      return;
    end
    m_dig[pos] = ref_decode(s[6:0]);
    if (m_dig[pos] == 4'hE) err_exp++;
    m_dp[pos]   = ~s[7];
    m_mask[pos] = 1'b1;
    if (m_mask == 4'hF) begin
      f.digs = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
      f.dp   = m_dp;
      exp_q.push_back(f);
      m_last_digs = f.digs;
      m_last_dp   = f.dp;
      m_mask      = 4'h0;
    end
  endtask

  // Hold {c, s} for len cycles; the model is updated up front so the
  // expected frame is queued before the DUT can publish it.
  task automatic run(input logic [3:0] c, input logic [7:0] s, input int len);
    if (len >= P + 1) model_event(c, s);
    if (len >= P + 1 + TMO) m_mask = 4'h0;
    com      = c;
    seg_data = s;
    last_val = {c, s};
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic settle_and_check_err(input string name);
    run(4'hF, 8'hFF, P + 8);
    chk(name, 32'(err_seen), 32'(err_exp));
  endtask

  task automatic model_reset();
    m_mask      = 4'h0;
    m_dp        = 4'h0;
    m_last_digs = 16'hFFFF;
    m_last_dp   = 4'h0;
    for (int n = 0; n < 4; n++) m_dig[n] = 4'hF;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_digits"}, {digit3, digit2, digit1, digit0}, 16'hFFFF);
    chk({tag, "_dp"},     dp_pos, 4'h0);
    chk({tag, "_fv"},     frame_valid, 1'b0);
    chk({tag, "_err"},    seg_err, 1'b0);
    chk({tag, "_stale"},  stale, 1'b0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (seg_err) err_seen++;
      if (frame_valid) begin
        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          frame_t f;
          f = exp_q.pop_front();
          chk("frame_digits", {digit3, digit2, digit1, digit0}, f.digs);
          chk("frame_dp", dp_pos, f.dp);
          chk("frame_stale", stale, 1'b0);
        end
      end
    end
  end

  initial begin
    logic [3:0] c;
    logic [7:0] s;
    int len;
    int q;

    model_reset();
    last_val = 12'hFFF;
    rst      = 1'b1;
    com      = 4'hF;
    seg_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Loopback 4,3,2,1 with dp on digit2, two frames
    for (int r = 0; r < 2; r++) begin
      run(com_of(3), seg_of(4, 1'b0), 40);
      run(com_of(2), seg_of(3, 1'b1), 40);
      run(com_of(1), seg_of(2, 1'b0), 40);
      run(com_of(0), seg_of(1, 1'b0), 40);
    end
    settle_and_check_err("loopback_no_err");
    chk("loopback_digits", {digit3, digit2, digit1, digit0}, 16'h4321);
    chk("loopback_dp", dp_pos, 4'b0100);

    // One-cycle glitch inside a digit0 dwell
    run(com_of(0), seg_of(1, 1'b0), 20);
    run(com_of(0), 8'h00, 1);
    run(com_of(0), seg_of(1, 1'b0), 20);
    run(com_of(1), seg_of(2, 1'b0), 30);
    run(com_of(2), seg_of(3, 1'b1), 30);
    run(com_of(3), seg_of(4, 1'b0), 30);
    settle_and_check_err("glitch_no_err");
    chk("glitch_digit0", digit0, 4'd1);

    // Illegal segment pattern on digit0
    run(4'b1110, 8'b1_0101010, 30);
    run(com_of(1), seg_of(5, 1'b0), 30);
    run(com_of(2), seg_of(6, 1'b0), 30);
    run(com_of(3), seg_of(7, 1'b0), 30);
    settle_and_check_err("badseg_err");
    chk("badseg_digit0", digit0, 4'hE);

    // Illegal com held 100 cycles between captures
    run(com_of(0), seg_of(9, 1'b1), 30);
    run(com_of(1), seg_of(8, 1'b0), 30);
    run(4'b1100, seg_of(5, 1'b0), 100);
    run(com_of(2), seg_of(0, 1'b0), 30);
    run(com_of(3), 8'hFF, 30);
    settle_and_check_err("badcom_err");

    // Timeout: partial frame, then frozen idle bus
    run(com_of(0), seg_of(3, 1'b0), 30);
    run(com_of(1), seg_of(3, 1'b0), 30);
    run(4'hF, 8'hFF, P + 1 + TMO + 50);
    chk("timeout_stale", stale, 1'b1);
    chk("timeout_hold_digits", {digit3, digit2, digit1, digit0}, m_last_digs);
    chk("timeout_hold_dp", dp_pos, m_last_dp);
    run(com_of(0), seg_of(6, 1'b0), 30);
    run(com_of(1), seg_of(7, 1'b1), 30);
    run(com_of(2), seg_of(8, 1'b0), 30);
    run(com_of(3), seg_of(9, 1'b0), 30);
    settle_and_check_err("timeout_err");
    chk("timeout_cleared", stale, 1'b0);

    // Reset after three captures
    run(com_of(0), seg_of(1, 1'b0), 30);
    run(com_of(1), seg_of(1, 1'b0), 30);
    run(com_of(2), seg_of(1, 1'b0), 30);
    run(4'hF, 8'hFF, 5);
    #2;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("midreset");
    run(com_of(3), seg_of(2, 1'b0), 30);
    check_reset_outputs("after_one");
    run(com_of(2), seg_of(3, 1'b0), 30);
    run(com_of(1), seg_of(4, 1'b0), 30);
    run(com_of(0), seg_of(5, 1'b1), 30);
    settle_and_check_err("reset_err");
    chk("reset_frame_digits", {digit3, digit2, digit1, digit0}, 16'h2345);

    // Randomized runs
    for (int i = 0; i < 300; i++) begin
      q = int'($urandom_range(0, 9));
      if (q < 7)       c = com_of(int'($urandom_range(0, 3)));
      else if (q == 7) c = 4'hF;
      else             c = BAD_COM[$urandom_range(0, 10)];
      q = int'($urandom_range(0, 9));
      if (q < 7)       s[6:0] = SEG_TAB[$urandom_range(0, 9)];
      else if (q == 7) s[6:0] = 7'h7F;
      else             s[6:0] = 7'($urandom_range(0, 127));
      s[7] = 1'($urandom_range(0, 1));
      if ({c, s} == last_val) s[7] = ~s[7];
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(1, P));
      else                           len = int'($urandom_range(P + 1, P + 25));
      run(c, s, len);
    end
    settle_and_check_err("random_err");

    repeat (20) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_err_count", 32'(err_seen), 32'(err_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_rx.md
# sevenseg_rx

Receive-side decoder for the multiplexed 4-digit 7-segment display bus. It watches the active-low common lines and segment lines that the display controller drives, filters out switching glitches, and decodes each segment pattern back to a BCD digit. It reassembles a full 4-digit frame and publishes it with a one-cycle valid strobe. Used for on-board loopback self-test of the stopwatch display path and for reading an external multiplexed display into the design.

## Interface
- P_STABLE_CNT, 15, cycles a {com, seg_data} value must stay unchanged before it is sampled; legal range 1..255.
- P_TIMEOUT, 200000, cycles without a sample event before the frame is declared stale; legal range 1..2^20-1.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- com  input  4  common lines, active-low one-hot: 1110 = digit0 (10 ms), 1101 = digit1 (100 ms), 1011 = digit2 (1 s), 0111 = digit3 (10 s).
- seg_data  input  8  {dp, g, f, e, d, c, b, a}, all active-low.
- digit0..digit3  output  4 each  decoded digits of the last complete frame.
- dp_pos  output  4  bit n set when the decimal point of digit n was lit in the last frame.
- frame_valid  output  1  one-cycle pulse when digit/dp outputs update.
- seg_err  output  1  one-cycle pulse on a sample event with an illegal com or segment code.
- stale  output  1  level; set on timeout, cleared by the next frame_valid.

## Operation
- Observed input: {com, seg_data} after the optional synchronizer (see Configuration).
- Stability counter (8 bit):
  - Cleared when the observed value differs from the previous observed value.
  - Otherwise increments, saturating at P_STABLE_CNT.
  - A sample event occurs on the single edge where the counter goes from P_STABLE_CNT-1 to P_STABLE_CNT. There is one event per stable period.
- com decode at a sample event:
  - The four one-hot codes select a position.
  - 1111 (all off) is ignored: no capture and no error.
  - Any other code pulses seg_err and captures nothing.
- Segment decode (bits 6:0):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
  - 1111111 (blank) → 4'hF with no error.
  - Any other pattern → 4'hE and a seg_err pulse. The value is still captured.
  - dp = ~seg_data[7].
- Capture into shadow registers:
  - A valid position writes shadow digit[n] and shadow dp[n], and sets mask[n].
  - Recapturing a position overwrites its shadow value; mask is unchanged.
- FSM states:
  - COLLECT: mask != 1111.
  - PUBLISH: entered on the edge where mask becomes 1111. On the next edge, shadow copies to the outputs, frame_valid = 1, mask clears, and the FSM returns to COLLECT.
  - A sample event arriving in PUBLISH is captured into the freshly cleared mask.
- Timeout counter (20 bit):
  - Cleared by every sample event, including ignored and error events.
  - On reaching P_TIMEOUT: stale = 1, mask clears, the counter holds at P_TIMEOUT, and the outputs keep their last frame.

## Timing
- Reset values:
  - digit0..3 = 4'hF, dp_pos = 0000, frame_valid = 0, seg_err = 0, stale = 0.
  - Stability counter, mask and timeout counter = 0; FSM = COLLECT.
  - Synchronizer flops = 8'hFF / 4'hF.
- Latency from the input edge to the sample event: sync depth (2, or 0) + P_STABLE_CNT + 1 cycles.
- frame_valid follows the 4th distinct capture by exactly 2 edges.
- seg_err asserts on the sample-event edge.
- The one-cycle mismatch between com and seg_data at digit switch-over is rejected by the stability filter whenever P_STABLE_CNT ≥ 2.
- Reset mid-frame discards the shadow registers and mask; no frame_valid is issued.

## Configuration
- SEVENSEG_RX_SYNC_EN:
  - Defined: com and seg_data pass through a 2-flop synchronizer before use, adding 2 cycles of latency. Required for pin inputs.
  - Undefined: inputs feed the filter directly. Allowed only for same-clock loopback.

## Test plan
- Loopback of digits 4,3,2,1 (digit3..0) with dp on digit2, 32000-cycle dwell per digit → frame_valid pulses with digit0=1, digit1=2, digit2=3, digit3=4, dp_pos=0100, and seg_err never asserts.
- 1-cycle glitch seg_data=8'h00 inside a digit0 dwell, with P_STABLE_CNT=15 → no capture of 8, and the next frame still shows digit0=1.
- seg_data=8'b1_0101010 on com=1110 → seg_err pulses once, and the next frame shows digit0=4'hE.
- com=1100 held 100 cycles → one seg_err pulse, mask unchanged, and no frame_valid.
- Inputs frozen at com=1111 for P_TIMEOUT cycles → stale=1 while outputs hold the previous frame; the next full frame brings frame_valid=1 and stale=0.
- rst asserted after 3 captures, then released → no frame_valid until 4 new captures, and all outputs read reset values meanwhile.
